// File: rtl/counter_pkg.sv
// Shared types and helpers for the mod-N counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Default count width: enough bits for 0..modv-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned modv);
        return ($clog2(modv) < 1) ? 1 : $clog2(modv);
    endfunction

    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modv);
        return (val >= modv) ? (modv - 1) : val;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating incrementer: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_inc && (r_cnt != '1)) begin
            w_cnt_next = r_cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/modn_down_counter.sv
// Programmable mod-N down counter with periodic/one-shot modes, terminal-count
// pulse and saturating wrap tally.
module modn_down_counter
    import counter_pkg::*;
#(
    parameter int unsigned MOD   = 5,
    parameter int unsigned WIDTH = cnt_width(MOD),
    parameter int unsigned WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_en,
    input  logic             i_oneshot,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_load_err,
    output logic [WRAPW-1:0] o_wrap_cnt
);

    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MOD - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             r_tc;
    logic             w_tc_next;
    logic             r_load_err;
    logic             w_load_err_next;
    logic             w_start_ok;
    logic             w_terminal;

    assign w_start_ok = i_start && (r_state != StRun);
    assign w_terminal = (r_state == StRun) && i_en && (r_count == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; priority is stop > load > start > count step
    always_comb begin
        w_state_next = r_state;
        if (i_stop) begin
            w_state_next = StIdle;
        end else if (!i_load) begin
            if (w_start_ok) begin
                w_state_next = StRun;
            end else if (w_terminal && i_oneshot) begin
                w_state_next = StDone;
            end
        end
    end

    // Output decode
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (r_state)
            StRun:   o_busy = 1'b1;
            StDone:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Count datapath; the count==0 branch always takes the terminal path, so no underflow
    always_comb begin
        w_count_next    = r_count;
        w_tc_next       = 1'b0;
        w_load_err_next = 1'b0;
        if (!i_stop) begin
            if (i_load) begin
                w_count_next    = WIDTH'(clamp_load(32'(i_load_val), MOD));
                w_load_err_next = (32'(i_load_val) >= MOD);
            end else if (w_start_ok) begin
                w_count_next = MaxCnt;
            end else if (w_terminal) begin
                w_tc_next    = 1'b1;
                w_count_next = i_oneshot ? '0 : MaxCnt;
            end else if ((r_state == StRun) && i_en) begin
                w_count_next = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_tc       <= w_tc_next;
            r_load_err <= w_load_err_next;
        end
    end

    sat_counter #(
        .WIDTH(WRAPW)
    ) u_wrap (
        .clk  (clk),
        .rst  (rst),
        .i_inc(w_tc_next),
        .o_cnt(o_wrap_cnt)
    );

    assign o_count    = r_count;
    assign o_tc       = r_tc;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_modn_down_counter.sv
// Scoreboard bench for modn_down_counter (MOD=5); a second instance with WRAPW=2
// shares the stimulus to exercise wrap tally saturation.
module tb_modn_down_counter;

    localparam int unsigned MOD   = 5;
    localparam int unsigned WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, stop, en, oneshot, load;
    logic [WIDTH-1:0] load_val;

    logic [WIDTH-1:0] count, count2;
    logic             tc, busy, done, load_err;
    logic             tc2, busy2, done2, load_err2;
    logic [7:0]       wrap_cnt;
    logic [1:0]       wrap_cnt2;

    always #5 clk = ~clk;

    modn_down_counter #(
        .MOD  (MOD),
        .WIDTH(WIDTH),
        .WRAPW(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_en      (en),
        .i_oneshot (oneshot),
        .i_load    (load),
        .i_load_val(load_val),
        .o_count   (count),
        .o_tc      (tc),
        .o_busy    (busy),
        .o_done    (done),
        .o_load_err(load_err),
        .o_wrap_cnt(wrap_cnt)
    );

    modn_down_counter #(
        .MOD  (MOD),
        .WIDTH(WIDTH),
        .WRAPW(2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_en      (en),
        .i_oneshot (oneshot),
        .i_load    (load),
        .i_load_val(load_val),
        .o_count   (count2),
        .o_tc      (tc2),
        .o_busy    (busy2),
        .o_done    (done2),
        .o_load_err(load_err2),
        .o_wrap_cnt(wrap_cnt2)
    );

    typedef struct {
        int cnt;
        int tc;
        int busy;
        int done;
        int lerr;
        int wrap;
        int wrap2;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: 0 idle, 1 run, 2 done
    int m_st, m_cnt, m_wrap, m_wrap2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_st    = 0;
        m_cnt   = 0;
        m_wrap  = 0;
        m_wrap2 = 0;
    endfunction

    task automatic step(input logic s, input logic sp, input logic e, input logic os,
                        input logic ld, input int lv);
        exp_t x;
        exp_t y;
        start    = s;
        stop     = sp;
        en       = e;
        oneshot  = os;
        load     = ld;
        load_val = WIDTH'(lv);
        x.tc   = 0;
        x.lerr = 0;
        if (sp) begin
            m_st = 0;
        end else if (ld) begin
            if (lv >= int'(MOD)) begin
                m_cnt  = MOD - 1;
                x.lerr = 1;
            end else begin
                m_cnt = lv;
            end
        end else if (s && m_st != 1) begin
            m_cnt = MOD - 1;
            m_st  = 1;
        end else if (m_st == 1 && e) begin
            if (m_cnt == 0) begin
                x.tc    = 1;
                m_wrap  = (m_wrap < 255) ? m_wrap + 1 : 255;
                m_wrap2 = (m_wrap2 < 3) ? m_wrap2 + 1 : 3;
                if (os) m_st = 2;
                else m_cnt = MOD - 1;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        x.cnt   = m_cnt;
        x.busy  = (m_st == 1) ? 1 : 0;
        x.done  = (m_st == 2) ? 1 : 0;
        x.wrap  = m_wrap;
        x.wrap2 = m_wrap2;
        q_exp.push_back(x);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            check_eq("sb_underflow", 0, 1);
        end else begin
            y = q_exp.pop_front();
            check_eq("sb_count", 32'(count), y.cnt);
            check_eq("sb_tc", 32'(tc), y.tc);
            check_eq("sb_busy", 32'(busy), y.busy);
            check_eq("sb_done", 32'(done), y.done);
            check_eq("sb_load_err", 32'(load_err), y.lerr);
            check_eq("sb_wrap_cnt", 32'(wrap_cnt), y.wrap);
            check_eq("sb_wrap_cnt_sat", 32'(wrap_cnt2), y.wrap2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {start, stop, en, oneshot, load} = '0;
        load_val = '0;
        model_reset();
        #3;
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_flags", {28'd0, tc, busy, done, load_err}, 0);
        check_eq("rst_wrap", 32'(wrap_cnt), 0);
        #4 rst = 1'b0;

        // Periodic mode: 4,3,2,1,0,4,... with tc every MOD cycles
        step(1, 0, 1, 0, 0, 0);
        check_eq("t1_start_count", 32'(count), 4);
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 1, 0, 0, 0);
            check_eq("t1_count", 32'(count), 4 - ((i + 1) % 5));
            check_eq("t1_tc", 32'(tc), ((i + 1) % 5 == 0) ? 1 : 0);
        end
        check_eq("t1_busy", 32'(busy), 1);
        check_eq("t1_wrap", 32'(wrap_cnt), 3);
        step(1, 0, 1, 0, 0, 0);
        check_eq("t1_restart_ignored", 32'(count), 3);

        // One-shot
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0);
        check_eq("t2_zero_still_run", 32'(busy), 1);
        step(0, 0, 1, 1, 0, 0);
        check_eq("t2_tc", 32'(tc), 1);
        check_eq("t2_done", 32'(done), 1);
        check_eq("t2_busy", 32'(busy), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0, 0);
        check_eq("t2_hold_count", 32'(count), 0);
        check_eq("t2_hold_tc", 32'(tc), 0);
        step(1, 0, 1, 1, 0, 0);
        check_eq("t2_restart_count", 32'(count), 4);
        check_eq("t2_restart_busy", 32'(busy), 1);

        // Enable gating from count=3
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check_eq("t3_en1", 32'(count), 2);
        step(0, 0, 0, 0, 0, 0);
        check_eq("t3_en0a", 32'(count), 2);
        step(0, 0, 0, 0, 0, 0);
        check_eq("t3_en0b", 32'(count), 2);
        check_eq("t3_no_tc", 32'(tc), 0);
        step(0, 0, 1, 0, 0, 0);
        check_eq("t3_en1b", 32'(count), 1);

        // Loads: in range, clamped, and on a terminal-event edge
        step(0, 0, 1, 0, 1, 2);
        check_eq("t4_load_count", 32'(count), 2);
        check_eq("t4_load_err0", 32'(load_err), 0);
        step(0, 0, 1, 0, 1, 7);
        check_eq("t4_clamp_count", 32'(count), 4);
        check_eq("t4_load_err1", 32'(load_err), 1);
        step(0, 0, 0, 0, 0, 0);
        check_eq("t4_load_err_pulse", 32'(load_err), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        check_eq("t4_at_zero", 32'(count), 0);
        step(0, 0, 1, 0, 1, 3);
        check_eq("t4_load_wins_count", 32'(count), 3);
        check_eq("t4_load_wins_tc", 32'(tc), 0);
        check_eq("t4_load_wins_wrap", 32'(wrap_cnt), 4);

        // stop beats load; start+stop in DONE goes idle
        step(0, 1, 1, 0, 1, 1);
        check_eq("t5_stop_count", 32'(count), 3);
        check_eq("t5_stop_busy", 32'(busy), 0);
        step(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
        check_eq("t5_done", 32'(done), 1);
        step(1, 1, 1, 1, 0, 0);
        check_eq("t5_startstop_done", 32'(done), 0);
        check_eq("t5_startstop_busy", 32'(busy), 0);

        // Asynchronous reset mid-count
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check_eq("t6_pre_rst_count", 32'(count), 2);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_count", 32'(count), 0);
        check_eq("t6_async_busy", 32'(busy), 0);
        check_eq("t6_async_wrap", 32'(wrap_cnt), 0);
        check_eq("t6_async_wrap_sat", 32'(wrap_cnt2), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Five terminal events: the 2-bit tally saturates at 3
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 25; i++) step(0, 0, 1, 0, 0, 0);
        check_eq("t6_wrap_sat", 32'(wrap_cnt2), 3);
        check_eq("t6_wrap_wide", 32'(wrap_cnt), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
